// File: rtl/map_pkg.sv
// Shared types and default parameters for the MAP core instruction memory.
package map_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam logic [DATA_W_DEF-1:0] END_MARK_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/ins_mem_ram.sv
// Single-port DEPTH x DATA_W array with synchronous write and registered read.
// No reset: contents and read register survive RST_N.
module ins_mem_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ins_mem_ctrl.sv
// Instruction memory with byte-stream program loader and registered fetch port.
// States: IDLE (no image) | LOAD (accepting bytes) | RUN (serving fetches).
module ins_mem_ctrl
    import map_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] END_MARK = END_MARK_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_load_done,
    output logic              o_ld_err,
    output logic [ADDR_W:0]   o_load_len,
    output logic              o_fetch_ready,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid,
    output logic              o_instr_oor
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   r_load_len;
    logic              r_ld_err;
    logic              r_load_done;
    logic              r_fetch_ready;
    logic              r_instr_valid;
    logic              r_instr_oor;
    logic              r_have_data;

    logic              w_full;
    logic              w_is_mark;
    logic              w_ram_we;
    logic              w_ptr_inc;
    logic              w_term;
    logic              w_ovf;
    logic              w_fetch_acc;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_rdata;

    assign w_full    = (r_ptr == DEPTH_C);
    assign w_is_mark = (i_ld_data == END_MARK);

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ptr_inc   = 1'b0;
        w_term      = 1'b0;
        w_ovf       = 1'b0;
        w_fetch_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ld_start)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // A restart drops any byte presented in the same cycle.
                if (!i_ld_start && i_ld_valid) begin
                    if (!w_full) begin
                        w_ram_we = 1'b1;
                        if (w_is_mark) begin
                            w_term      = 1'b1;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_ptr_inc = 1'b1;
                        end
                    end else begin
                        w_term      = 1'b1;
                        w_ovf       = !w_is_mark;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_ld_start)
                    w_state_nxt = ST_LOAD;
                else
                    w_fetch_acc = i_fetch_req;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_load_len    <= '0;
            r_ld_err      <= 1'b0;
            r_load_done   <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_oor   <= 1'b0;
            r_have_data   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_load_done   <= w_term;
            r_fetch_ready <= (w_state_nxt == ST_RUN);
            r_instr_valid <= w_fetch_acc;
            if (i_ld_start) begin
                r_ptr      <= '0;
                r_load_len <= '0;
                r_ld_err   <= 1'b0;
            end else begin
                if (w_ptr_inc)
                    r_ptr <= r_ptr + 1'b1;
                // On overflow r_ptr already equals DEPTH, so one assignment covers both endings.
                if (w_term)
                    r_load_len <= r_ptr;
                if (w_ovf)
                    r_ld_err <= 1'b1;
            end
            if (w_fetch_acc) begin
                r_instr_oor <= ({1'b0, i_fetch_addr} >= r_load_len);
                r_have_data <= 1'b1;
            end
        end
    end

    assign w_ram_addr = (r_state == ST_LOAD) ? r_ptr[ADDR_W-1:0] : i_fetch_addr;

    ins_mem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_re    (w_fetch_acc),
        .i_addr  (w_ram_addr),
        .i_wdata (i_ld_data),
        .o_rdata (w_rdata)
    );

    // The RAM read register is not reset, so INSTR reads zero until the first fetch.
    assign o_instr       = !r_have_data ? '0 : (r_instr_oor ? END_MARK : w_rdata);
    assign o_load_done   = r_load_done;
    assign o_ld_err      = r_ld_err;
    assign o_load_len    = r_load_len;
    assign o_fetch_ready = r_fetch_ready;
    assign o_instr_valid = r_instr_valid;
    assign o_instr_oor   = r_instr_oor;

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Randomized bench for ins_mem_ctrl against a byte-array reference model of the loaded image.
module tb_ins_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       load_done;
    logic       ld_err;
    logic [8:0] load_len;
    logic       fetch_ready;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_oor;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [256];
    int         m_len;
    bit         m_err;
    logic [7:0] stream [$];

    ins_mem_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ld_start    (ld_start),
        .i_ld_valid    (ld_valid),
        .i_ld_data     (ld_data),
        .o_load_done   (load_done),
        .o_ld_err      (ld_err),
        .o_load_len    (load_len),
        .o_fetch_ready (fetch_ready),
        .i_fetch_req   (fetch_req),
        .i_fetch_addr  (fetch_addr),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_instr_oor   (instr_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse LD_START, then stream bytes up to the terminating one; model mirrors the loader rules.
    task automatic run_load(input bit gaps);
        int n = 0;
        int t = -1;
        m_err = 0;
        for (int i = 0; i < stream.size(); i++) begin
            if (n == 256) begin
                m_len = 256;
                m_err = (stream[i] != 8'hFF);
                t = i;
                break;
            end
            m_mem[n] = stream[i];
            if (stream[i] == 8'hFF) begin
                m_len = n;
                t = i;
                break;
            end
            n++;
        end
        ld_start = 1; cyc(); ld_start = 0;
        checks++;
        if (fetch_ready !== 1'b0 || load_len !== 9'd0 || ld_err !== 1'b0) begin
            errors++;
            $display("FAIL load_start: ready=%0b len=%0d err=%0b required 0 0 0", fetch_ready, load_len, ld_err);
        end
        for (int i = 0; i <= t; i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                ld_valid = 0; ld_data = 8'hFF; cyc();
            end
            ld_valid = 1; ld_data = stream[i]; cyc();
            if (i < t) begin
                if (load_done !== 1'b0 || fetch_ready !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL load_busy: byte %0d done=%0b ready=%0b required 0 0", i, load_done, fetch_ready);
                end
            end
        end
        ld_valid = 0;
        checks++;
        if (load_done !== 1'b1 || fetch_ready !== 1'b1 || load_len !== 9'(m_len) || ld_err !== m_err) begin
            errors++;
            $display("FAIL load_end: done=%0b ready=%0b len=%0d err=%0b required 1 1 %0d %0b",
                     load_done, fetch_ready, load_len, ld_err, m_len, m_err);
        end
        cyc();
        checks++;
        if (load_done !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done_pulse: done=%0b ready=%0b required 0 1", load_done, fetch_ready);
        end
    endtask

    // Issue one fetch and compare against the image model.
    task automatic fetch_chk(input logic [7:0] a, input string tag);
        bit         e_oor = (int'(a) >= m_len);
        logic [7:0] e_ins = e_oor ? 8'hFF : m_mem[a];
        fetch_req = 1; fetch_addr = a; cyc(); fetch_req = 0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== e_ins || instr_oor !== e_oor) begin
            errors++;
            $display("FAIL %s: addr=%0d valid=%0b instr=%h oor=%0b required 1 %h %0b",
                     tag, a, instr_valid, instr, instr_oor, e_ins, e_oor);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; ld_start = 0; ld_valid = 0; ld_data = 0; fetch_req = 0; fetch_addr = 0;
        cyc(); cyc();
        rst_n = 1; cyc();
        m_len = 0; m_err = 0;
        checks++;
        if (load_done !== 0 || ld_err !== 0 || load_len !== 0 || fetch_ready !== 0 ||
            instr !== 0 || instr_valid !== 0 || instr_oor !== 0) begin
            errors++;
            $display("FAIL reset: done=%0b err=%0b len=%0d ready=%0b instr=%h valid=%0b oor=%0b required all 0",
                     load_done, ld_err, load_len, fetch_ready, instr, instr_valid, instr_oor);
        end
    endtask

    task automatic test_basic_load();
        stream = '{8'h40, 8'h5F, 8'h80, 8'hFF};
        run_load(0);
        fetch_chk(8'd1, "basic_addr1");
        fetch_chk(8'd3, "basic_addr3");
        fetch_chk(8'd200, "basic_addr200");
        fetch_chk(8'd0, "basic_addr0");
        cyc();
        checks++;
        if (instr_valid !== 1'b0 || instr !== 8'h40) begin
            errors++;
            $display("FAIL basic_hold: valid=%0b instr=%h required 0 40", instr_valid, instr);
        end
    endtask

    task automatic test_random_loads();
        logic [7:0] last;
        for (int it = 0; it < 4; it++) begin
            stream = {};
            for (int k = 0; k < int'($urandom_range(0, 30)); k++)
                stream.push_back(8'($urandom_range(0, 254)));
            stream.push_back(8'hFF);
            stream.push_back(8'($urandom_range(0, 254)));
            run_load(1);
            last = instr;
            for (int k = 0; k < 24; k++) begin
                if ($urandom % 5 == 0) begin
                    cyc();
                    checks++;
                    if (instr_valid !== 1'b0 || instr !== last) begin
                        errors++;
                        $display("FAIL rand_idle: valid=%0b instr=%h required 0 %h", instr_valid, instr, last);
                    end
                end else begin
                    fetch_chk(($urandom % 2) ? 8'($urandom_range(0, m_len > 255 ? 255 : m_len))
                                             : 8'($urandom_range(0, 255)), "rand_fetch");
                    last = instr;
                end
            end
        end
    endtask

    task automatic test_overflow();
        stream = {};
        for (int k = 0; k < 255; k++) stream.push_back(8'(k));
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        run_load(0);
        fetch_chk(8'd255, "ovf_addr255");
        fetch_chk(8'd254, "ovf_addr254");
        fetch_chk(8'd0, "ovf_addr0");
    endtask

    task automatic test_exact_full();
        stream = {};
        for (int k = 0; k < 256; k++) stream.push_back(8'($urandom_range(0, 254)));
        stream.push_back(8'hFF);
        run_load(0);
        fetch_chk(8'd255, "full_addr255");
        fetch_chk(8'd128, "full_addr128");
    endtask

    task automatic test_back_to_back();
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
        run_load(0);
        for (int a = 0; a < 3; a++) begin
            fetch_req = 1; fetch_addr = 8'(a); cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr !== m_mem[a] || instr_oor !== 1'b0) begin
                errors++;
                $display("FAIL b2b: addr=%0d valid=%0b instr=%h oor=%0b required 1 %h 0",
                         a, instr_valid, instr, instr_oor, m_mem[a]);
            end
        end
        ld_start = 1; fetch_req = 1; fetch_addr = 8'd1; cyc();
        ld_start = 0; fetch_req = 0;
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b0 || load_len !== 9'd0) begin
            errors++;
            $display("FAIL start_vs_fetch: valid=%0b ready=%0b len=%0d required 0 0 0",
                     instr_valid, fetch_ready, load_len);
        end
        ld_valid = 1; ld_data = 8'h77; cyc();
        ld_data = 8'hFF; cyc(); ld_valid = 0;
        m_mem[0] = 8'h77; m_len = 1;
        checks++;
        if (load_done !== 1'b1 || load_len !== 9'd1) begin
            errors++;
            $display("FAIL reload_end: done=%0b len=%0d required 1 1", load_done, load_len);
        end
        cyc();
        fetch_chk(8'd0, "reload_addr0");
        fetch_chk(8'd1, "reload_addr1");
    endtask

    task automatic test_reset_midload();
        ld_start = 1; cyc(); ld_start = 0;
        ld_valid = 1; ld_data = 8'hA1; cyc();
        ld_data = 8'hA2; cyc(); ld_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if (load_done !== 0 || ld_err !== 0 || load_len !== 0 || fetch_ready !== 0 ||
            instr !== 0 || instr_valid !== 0 || instr_oor !== 0) begin
            errors++;
            $display("FAIL reset_midload: done=%0b err=%0b len=%0d ready=%0b instr=%h valid=%0b oor=%0b required all 0",
                     load_done, ld_err, load_len, fetch_ready, instr, instr_valid, instr_oor);
        end
        cyc();
        rst_n = 1; m_len = 0;
        ld_valid = 1; ld_data = 8'hFF; fetch_req = 1; fetch_addr = 8'd0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (instr_valid !== 1'b0 || fetch_ready !== 1'b0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: valid=%0b ready=%0b done=%0b required 0 0 0",
                         instr_valid, fetch_ready, load_done);
            end
        end
        ld_valid = 0; fetch_req = 0;
        stream = '{8'hFF};
        run_load(0);
        fetch_chk(8'd0, "empty_addr0");
        fetch_chk(8'd1, "empty_addr1");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_random_loads();
        test_overflow();
        test_back_to_back();
        test_exact_full();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
